// File: rtl/adma_atx_splitter.sv
// Splits a DMA descriptor (start addresses + beat count) into AXI INCR burst requests
// that never cross a 4 KB page on either the read or the write address.
module adma_atx_splitter #(
    parameter int DMA_CHN_NUM = 4,
    parameter int SRC_ADDR_W  = 32,
    parameter int DST_ADDR_W  = 32,
    parameter int MST_ID_W    = 5,
    parameter int ATX_LEN_W   = 8,
    parameter int ATX_DATA_W  = 256,
    parameter int MAX_BURST   = 16,
    parameter int DESC_LEN_W  = 16,
    localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DMA_CHN_NUM_W-1:0] desc_chn_id,
    input  logic [MST_ID_W-1:0]      desc_id,
    input  logic [SRC_ADDR_W-1:0]    desc_src_addr,
    input  logic [DST_ADDR_W-1:0]    desc_dst_addr,
    input  logic [DESC_LEN_W-1:0]    desc_len,
    input  logic                     desc_vld,
    output logic                     desc_rdy,
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_arid,
    output logic [SRC_ADDR_W-1:0]    atx_araddr,
    output logic [ATX_LEN_W-1:0]     atx_arlen,
    output logic [1:0]               atx_arburst,
    output logic [MST_ID_W-1:0]      atx_awid,
    output logic [DST_ADDR_W-1:0]    atx_awaddr,
    output logic [ATX_LEN_W-1:0]     atx_awlen,
    output logic [1:0]               atx_awburst,
    output logic                     atx_vld,
    input  logic                     atx_rdy,
    output logic                     desc_done,
    output logic                     busy
);

    localparam int BPB      = ATX_DATA_W / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    // Counter width wide enough for the remaining length and a full page of beats.
    localparam int CW       = ((DESC_LEN_W > 13) ? DESC_LEN_W : 13) + 1;
    localparam logic [SRC_ADDR_W-1:0] SRC_MASK = ~SRC_ADDR_W'(BPB - 1);
    localparam logic [DST_ADDR_W-1:0] DST_MASK = ~DST_ADDR_W'(BPB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [DMA_CHN_NUM_W-1:0] r_chn;
    logic [MST_ID_W-1:0]      r_id;
    logic [SRC_ADDR_W-1:0]    r_src;
    logic [DST_ADDR_W-1:0]    r_dst;
    logic [DESC_LEN_W-1:0]    r_rem;
    logic [CW-1:0]            r_beats;
    logic [SRC_ADDR_W-1:0]    r_araddr;
    logic [DST_ADDR_W-1:0]    r_awaddr;
    logic [ATX_LEN_W-1:0]     r_len;
    logic                     r_done;

    logic [12:0]              w_src_room13;
    logic [12:0]              w_dst_room13;
    logic [CW-1:0]            w_src_room;
    logic [CW-1:0]            w_dst_room;
    logic [CW-1:0]            w_beats;
    logic [SRC_ADDR_W-1:0]    w_src_step;
    logic [DST_ADDR_W-1:0]    w_dst_step;
    logic [DESC_LEN_W-1:0]    w_rem_next;

    // Beats left before each address reaches the next 4 KB page.
    assign w_src_room13 = 13'h1000 - {1'b0, r_src[11:0]};
    assign w_dst_room13 = 13'h1000 - {1'b0, r_dst[11:0]};
    assign w_src_room   = CW'(w_src_room13 >> BPB_LOG2);
    assign w_dst_room   = CW'(w_dst_room13 >> BPB_LOG2);

    always_comb begin
        w_beats = CW'(r_rem);
        if (w_beats > CW'(MAX_BURST)) w_beats = CW'(MAX_BURST);
        if (w_beats > w_src_room)     w_beats = w_src_room;
        if (w_beats > w_dst_room)     w_beats = w_dst_room;
    end

    assign w_src_step = SRC_ADDR_W'(r_beats) << BPB_LOG2;
    assign w_dst_step = DST_ADDR_W'(r_beats) << BPB_LOG2;
    assign w_rem_next = r_rem - DESC_LEN_W'(r_beats);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        desc_rdy = 1'b0;
        atx_vld  = 1'b0;
        busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                desc_rdy = 1'b1;
                busy     = 1'b0;
                if (desc_vld && (desc_len != '0)) w_next = S_CALC;
            end
            S_CALC: w_next = S_ISSUE;
            S_ISSUE: begin
                atx_vld = 1'b1;
                if (atx_rdy) w_next = (w_rem_next == '0) ? S_IDLE : S_CALC;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chn    <= '0;
            r_id     <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_rem    <= '0;
            r_beats  <= '0;
            r_araddr <= '0;
            r_awaddr <= '0;
            r_len    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (desc_vld) begin
                        r_chn  <= desc_chn_id;
                        r_id   <= desc_id;
                        r_src  <= desc_src_addr & SRC_MASK;
                        r_dst  <= desc_dst_addr & DST_MASK;
                        r_rem  <= desc_len;
                        r_done <= (desc_len == '0);
                    end
                end
                S_CALC: begin
                    r_araddr <= r_src;
                    r_awaddr <= r_dst;
                    r_len    <= ATX_LEN_W'(w_beats - CW'(1));
                    r_beats  <= w_beats;
                end
                S_ISSUE: begin
                    if (atx_rdy) begin
                        r_src  <= r_src + w_src_step;
                        r_dst  <= r_dst + w_dst_step;
                        r_rem  <= w_rem_next;
                        r_done <= (w_rem_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign atx_chn_id  = r_chn;
    assign atx_arid    = r_id;
    assign atx_awid    = r_id;
    assign atx_araddr  = r_araddr;
    assign atx_awaddr  = r_awaddr;
    assign atx_arlen   = r_len;
    assign atx_awlen   = r_len;
    assign atx_arburst = 2'b01;
    assign atx_awburst = 2'b01;
    assign desc_done   = r_done;

endmodule

// File: tb/tb_adma_atx_splitter.sv
// Scoreboard bench for adma_atx_splitter: expected bursts are queued at stimulus time
// and checked by an independent monitor on every accepted burst request.
module tb_adma_atx_splitter;

    localparam int BPB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  desc_chn_id;
    logic [4:0]  desc_id;
    logic [31:0] desc_src_addr;
    logic [31:0] desc_dst_addr;
    logic [15:0] desc_len;
    logic        desc_vld;
    logic        desc_rdy;
    logic [1:0]  atx_chn_id;
    logic [4:0]  atx_arid;
    logic [31:0] atx_araddr;
    logic [7:0]  atx_arlen;
    logic [1:0]  atx_arburst;
    logic [4:0]  atx_awid;
    logic [31:0] atx_awaddr;
    logic [7:0]  atx_awlen;
    logic [1:0]  atx_awburst;
    logic        atx_vld;
    logic        atx_rdy;
    logic        desc_done;
    logic        busy;

    typedef struct {
        logic [1:0]  chn;
        logic [4:0]  id;
        logic [31:0] ar;
        logic [31:0] aw;
        logic [7:0]  len;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rdy_hold_low = 1'b0;
    bit   exp_done = 1'b0;

    always #5 clk = ~clk;

    adma_atx_splitter dut (
        .clk(clk), .rst(rst),
        .desc_chn_id(desc_chn_id), .desc_id(desc_id),
        .desc_src_addr(desc_src_addr), .desc_dst_addr(desc_dst_addr),
        .desc_len(desc_len), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
        .atx_chn_id(atx_chn_id), .atx_arid(atx_arid), .atx_araddr(atx_araddr),
        .atx_arlen(atx_arlen), .atx_arburst(atx_arburst), .atx_awid(atx_awid),
        .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
        .atx_vld(atx_vld), .atx_rdy(atx_rdy),
        .desc_done(desc_done), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] c, input logic [4:0] i, input logic [31:0] ar,
                            input logic [31:0] aw, input logic [7:0] len, input bit last);
        exp_t e;
        e.chn = c; e.id = i; e.ar = ar; e.aw = aw; e.len = len; e.last = last;
        exp_q.push_back(e);
    endtask

    // Reference: greedily take the largest burst allowed by length, MAX_BURST and both pages.
    task automatic push_model(input logic [1:0] c, input logic [4:0] i, input logic [31:0] src,
                              input logic [31:0] dst, input logic [15:0] len);
        int          rem;
        int          b;
        int          room;
        logic [31:0] s;
        logic [31:0] d;
        rem = int'(len);
        s = src & ~32'h1F;
        d = dst & ~32'h1F;
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            room = (4096 - int'(s[11:0])) / BPB;
            if (b > room) b = room;
            room = (4096 - int'(d[11:0])) / BPB;
            if (b > room) b = room;
            push_exp(c, i, s, d, 8'(b - 1), rem == b);
            s = s + 32'(b * BPB);
            d = d + 32'(b * BPB);
            rem = rem - b;
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [4:0] i, input logic [31:0] s,
                        input logic [31:0] d, input logic [15:0] l);
        int t = 0;
        @(posedge clk); #1;
        desc_chn_id = c; desc_id = i; desc_src_addr = s; desc_dst_addr = d; desc_len = l;
        desc_vld = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!desc_rdy && t < 500);
        if (!desc_rdy) begin
            n_checks++; n_fail++;
            $display("FAIL desc_accept: desc_rdy still %0b after %0d cycles, expected 1", desc_rdy, t);
        end
        @(posedge clk); #1;
        desc_vld = 1'b0;
        desc_chn_id = 2'($urandom); desc_id = 5'($urandom);
        desc_src_addr = $urandom; desc_dst_addr = $urandom; desc_len = 16'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(exp_q.size() == 0 && !busy && !exp_done && !desc_done) && t < 3000);
        if (t >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: %0d bursts outstanding, busy %0b, expected 0 and 0", exp_q.size(), busy);
        end
    endtask

    initial begin
        atx_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            atx_rdy = rdy_hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected bursts on handshakes, checks hold stability and desc_done timing.
    initial begin
        logic [31:0] p_ar, p_aw;
        logic [7:0]  p_arl, p_awl;
        logic [4:0]  p_id;
        logic [1:0]  p_chn;
        bit          pend = 1'b0;
        bit          nd;
        int          end_a;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_done = 1'b0;
                pend = 1'b0;
            end else begin
                chk("desc_done", desc_done, exp_done);
                nd = 1'b0;
                if (pend) begin
                    chk("hold_vld", atx_vld, 1);
                    chk("hold_araddr", atx_araddr, p_ar);
                    chk("hold_awaddr", atx_awaddr, p_aw);
                    chk("hold_arlen", atx_arlen, p_arl);
                    chk("hold_awlen", atx_awlen, p_awl);
                    chk("hold_id", {atx_arid, atx_awid, atx_chn_id}, {p_id, p_id, p_chn});
                end
                if (atx_vld && atx_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_burst: araddr %0h issued, expected no burst", atx_araddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("chn_id", atx_chn_id, e.chn);
                        chk("arid", atx_arid, e.id);
                        chk("awid", atx_awid, e.id);
                        chk("araddr", atx_araddr, e.ar);
                        chk("awaddr", atx_awaddr, e.aw);
                        chk("arlen", atx_arlen, e.len);
                        chk("awlen", atx_awlen, e.len);
                        chk("bursts", {atx_arburst, atx_awburst}, 4'b0101);
                        nd = e.last;
                    end
                    end_a = int'(atx_araddr[11:0]) + (int'(atx_arlen) + 1) * BPB;
                    chk("ar_4k", end_a <= 4096, 1);
                    end_a = int'(atx_awaddr[11:0]) + (int'(atx_awlen) + 1) * BPB;
                    chk("aw_4k", end_a <= 4096, 1);
                end
                if (desc_vld && desc_rdy && desc_len == 16'd0) nd = 1'b1;
                pend  = atx_vld && !atx_rdy;
                p_ar  = atx_araddr; p_aw = atx_awaddr;
                p_arl = atx_arlen;  p_awl = atx_awlen;
                p_id  = atx_arid;   p_chn = atx_chn_id;
                exp_done = nd;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d;
        rst = 1'b1; desc_vld = 1'b0;
        desc_chn_id = '0; desc_id = '0; desc_src_addr = '0; desc_dst_addr = '0; desc_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_desc_rdy", desc_rdy, 1);
        chk("rst_atx_vld", atx_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addrs", {atx_araddr, atx_awaddr}, 64'h0);
        chk("rst_fields", {atx_arlen, atx_awlen, atx_arid, atx_awid, atx_chn_id}, 0);

        push_exp(2'd1, 5'd3, 32'h1000, 32'h2000, 8'd15, 0);
        push_exp(2'd1, 5'd3, 32'h1200, 32'h2200, 8'd15, 0);
        push_exp(2'd1, 5'd3, 32'h1400, 32'h2400, 8'd7, 1);
        send(2'd1, 5'd3, 32'h1000, 32'h2000, 16'd40);
        wait_idle();

        push_exp(2'd2, 5'd9, 32'h0FC0, 32'h5000, 8'd1, 0);
        push_exp(2'd2, 5'd9, 32'h1000, 32'h5040, 8'd5, 1);
        send(2'd2, 5'd9, 32'h0FC0, 32'h5000, 16'd8);
        wait_idle();

        push_exp(2'd3, 5'd17, 32'h0000, 32'h1FE0, 8'd0, 0);
        push_exp(2'd3, 5'd17, 32'h0020, 32'h2000, 8'd2, 1);
        send(2'd3, 5'd17, 32'h0, 32'h1FE0, 16'd4);
        wait_idle();

        // Stall: ready held low, request must hold; also first-request latency.
        rdy_hold_low = 1'b1;
        push_exp(2'd0, 5'd4, 32'h3000, 32'h4000, 8'd3, 1);
        send(2'd0, 5'd4, 32'h3000, 32'h4000, 16'd4);
        @(negedge clk);
        chk("lat_calc_vld", atx_vld, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_vld", atx_vld, 1);
            chk("stall_desc_rdy", desc_rdy, 0);
            chk("stall_araddr", atx_araddr, 32'h3000);
            chk("stall_awlen", atx_awlen, 8'd3);
        end
        rdy_hold_low = 1'b0;
        wait_idle();

        send(2'd2, 5'd7, 32'h100, 32'h200, 16'd0);
        @(negedge clk);
        chk("len0_done", desc_done, 1);
        chk("len0_desc_rdy", desc_rdy, 1);
        chk("len0_vld", atx_vld, 0);
        @(negedge clk);
        chk("len0_done_end", desc_done, 0);
        wait_idle();

        // Reset while a request is waiting in ISSUE.
        rdy_hold_low = 1'b1;
        push_model(2'd1, 5'd11, 32'h7000, 32'h8000, 16'd20);
        send(2'd1, 5'd11, 32'h7000, 32'h8000, 16'd20);
        repeat (2) @(negedge clk);
        chk("pre_rst_vld", atx_vld, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_issue_vld", atx_vld, 0);
        chk("rst_issue_desc_rdy", desc_rdy, 1);
        chk("rst_issue_busy", busy, 0);
        chk("rst_issue_done", desc_done, 0);
        chk("rst_issue_araddr", atx_araddr, 32'h0);
        rdy_hold_low = 1'b0;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  c;
            logic [4:0]  i;
            logic [15:0] l;
            c = 2'($urandom_range(0, 3));
            i = 5'($urandom_range(0, 31));
            s = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) s[11:8] = 4'hF;
            if ($urandom_range(0, 1) == 1) d[11:8] = 4'hF;
            if ($urandom_range(0, 7) == 0) s[31:12] = '1;
            l = (n % 9 == 4) ? 16'd0 : 16'($urandom_range(1, 70));
            push_model(c, i, s, d, l);
            send(c, i, s, d, l);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
